// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential radix-2 shift-and-add unsigned multiplier. One partial product
//   is added per clock. It uses the same Busy/Ready handshake as the divider.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   Start         request pulse, sampled only while Busy=0
//   Multiplicand  operand A (unsigned, WIDTH bits), latched on accept
//   Multiplier    operand B (unsigned, WIDTH bits), latched on accept
//   Res           registered 2*WIDTH-bit product
//   Busy          high while a multiplication is running
//   Ready         sticky level: Res holds the result of the last accepted request
//
// Optional build macro
//   SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN: finish as soon as the remaining
//   multiplier bits are all zero. Products are identical either way; only the
//   latency changes.

module shift_add_multiplier #(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic [2*WIDTH-1:0]   Res,
  output logic                 Busy,
  output logic                 Ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplr_shift;
  logic               last_iter;

  always_comb begin
    acc_sum    = acc + (mplr[0] ? mcand : '0);
    mplr_shift = mplr >> 1;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
    // No set bits left means every remaining iteration would add nothing.
    last_iter  = (mplr_shift == '0);
`else
    last_iter  = (cnt == CW'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      Res   <= '0;
      Busy  <= 1'b0;
      Ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            if (Multiplicand == '0 || Multiplier == '0) begin
              // Zero product needs no iterations.
              Res   <= '0;
              Ready <= 1'b1;
              Busy  <= 1'b0;
            end else begin
              mcand <= {{WIDTH{1'b0}}, Multiplicand};
              mplr  <= Multiplier;
              acc   <= '0;
              cnt   <= '0;
              Ready <= 1'b0;
              Busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mplr  <= mplr_shift;
          cnt   <= cnt + CW'(1);
          if (last_iter) begin
            // Res takes the sum including this edge's partial product.
            Res   <= acc_sum;
            Busy  <= 1'b0;
            Ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier
//   Directed bench for shift_add_multiplier at WIDTH=12. Expected products and
//   latencies are hand-computed constants; latency expectations follow the
//   SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN setting of the build.

module tb_shift_add_multiplier;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           Start = 1'b0;
  logic [W-1:0]   Multiplicand = '0;
  logic [W-1:0]   Multiplier = '0;
  logic [2*W-1:0] Res;
  logic           Busy;
  logic           Ready;

  int tests_run = 0;
  int failed = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Res          (Res),
    .Busy         (Busy),
    .Ready        (Ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // RUN edges expected for a non-zero multiplication with multiplier b.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
    return (b == '0) ? 0 : h + 1;
`else
    return (b == '0) ? 0 : W;
`endif
  endfunction

  // Counts edges until Busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
    Multiplicand = a;
    Multiplier   = b;
    Start        = 1'b1;
    tick();
    Start        = 1'b0;
    wait_idle(n);
  endtask

  initial begin
    int n;
    int pre;
    int bad_hold;

    tick();
    tick();
    reset = 1'b0;
    chk("reset_res", Res, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_ready", Ready, 0);

    // 1: maximum operands
    Multiplicand = 12'd4095;
    Multiplier   = 12'd4095;
    Start        = 1'b1;
    tick();
    Start = 1'b0;
    chk("max_busy_after_accept", Busy, 1);
    chk("max_ready_after_accept", Ready, 0);
    wait_idle(n);
    chk("max_latency", n, exp_lat(12'd4095));
    chk("max_res", Res, 24'hFFE001);
    chk("max_ready", Ready, 1);
    chk("max_busy", Busy, 0);

    // 2: latency depends on the multiplier's top set bit only in early builds
    run_mult(12'd2205, 12'd3, n);
    chk("a2205x3_res", Res, 6615);
    chk("a2205x3_lat", n, exp_lat(12'd3));
    run_mult(12'd3, 12'd2205, n);
    chk("a3x2205_res", Res, 6615);
    chk("a3x2205_lat", n, 12);
    chk("a3x2205_ready", Ready, 1);

    // 3: zero fast path
    run_mult(12'd0, 12'd1234, n);
    chk("zero_a_busy_edges", n, 0);
    chk("zero_a_res", Res, 0);
    chk("zero_a_ready", Ready, 1);
    run_mult(12'd6615 % 4096, 12'd0, n);
    run_mult(12'd1234, 12'd0, n);
    chk("zero_b_busy_edges", n, 0);
    chk("zero_b_res", Res, 0);
    chk("zero_b_ready", Ready, 1);

    // 4: Start during RUN ignored, operand changes ignored
    Multiplicand = 12'd100;
    Multiplier   = 12'd200;
    Start        = 1'b1;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    Multiplicand = 12'd7;
    Multiplier   = 12'd7;
    Start        = 1'b1;
    tick();
    Start        = 1'b0;
    Multiplicand = 12'd4000;
    Multiplier   = 12'd3999;
    chk("busy_mid_run", Busy, 1);
    chk("res_held_mid_run", Res, 0);
    chk("ready_low_mid_run", Ready, 0);
    wait_idle(n);
    chk("ignore_start_lat", n + 5, exp_lat(12'd200));
    chk("ignore_start_res", Res, 20000);
    tick();
    chk("no_queued_busy", Busy, 0);
    chk("no_queued_res", Res, 20000);

    // 5: reset mid-operation, with Start asserted on the reset edge
    Multiplicand = 12'd4095;
    Multiplier   = 12'd4095;
    Start        = 1'b1;
    tick();
    Start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    Start = 1'b1;
    tick();
    reset = 1'b0;
    Start = 1'b0;
    chk("midreset_res", Res, 0);
    chk("midreset_busy", Busy, 0);
    chk("midreset_ready", Ready, 0);
    repeat (15) tick();
    chk("midreset_no_ready", Ready, 0);
    chk("midreset_no_busy", Busy, 0);
    run_mult(12'd15, 12'd17, n);
    chk("a15x17_res", Res, 255);
    chk("a15x17_lat", n, exp_lat(12'd17));

    // 6: Start held high, back-to-back requests
    Multiplicand = 12'd10;
    Multiplier   = 12'd10;
    Start        = 1'b1;
    tick();
    wait_idle(n);
    chk("b2b_first_lat", n, exp_lat(12'd10));
    chk("b2b_first_res", Res, 100);
    chk("b2b_first_ready", Ready, 1);
    Multiplicand = 12'd20;
    Multiplier   = 12'd20;
    tick();
    chk("b2b_second_busy", Busy, 1);
    chk("b2b_ready_one_cycle", Ready, 0);
    Start = 1'b0;
    bad_hold = 0;
    pre = 0;
    while (Busy === 1'b1 && pre < 100) begin
      if (Res !== 24'd100) bad_hold++;
      tick();
      pre++;
    end
    chk("b2b_res_held", bad_hold, 0);
    chk("b2b_second_lat", pre, exp_lat(12'd20));
    chk("b2b_second_res", Res, 400);
    chk("b2b_second_ready", Ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
